// File: rtl/step_clk_pkg.sv
// -----------------------------------------------------------------------------
// step_clk_pkg
// Shared types and constants for the step clock generator.
//   step_state_t : cpu_clk FSM state (manual/run x low/high phase)
//   KEY_IDLE     : idle (released) level of the active-low push-button
//   SW_IDLE      : idle level of the run/step switch (manual)
// -----------------------------------------------------------------------------
package step_clk_pkg;

   typedef enum logic [1:0] {
      MAN_LO = 2'd0,
      MAN_HI = 2'd1,
      RUN_LO = 2'd2,
      RUN_HI = 2'd3
   } step_state_t;

   localparam logic KEY_IDLE = 1'b1;
   localparam logic SW_IDLE  = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// 2-flop synchronizer followed by a hold-time debouncer. A new level is
// accepted once the synchronized input has differed from the stable level for
// DEBOUNCE_CYCLES consecutive clocks; any return to the stable level restarts
// the count.
// Ports:
//   clk      in  board clock
//   reset    in  synchronous active-low reset
//   i_raw    in  raw asynchronous input
//   o_stable out debounced level (RESET_VAL after reset)
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int   DEBOUNCE_CYCLES = 1_000_000,
   parameter logic RESET_VAL       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable
);

   localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1  <= RESET_VAL;
         r_sync2  <= RESET_VAL;
         r_stable <= RESET_VAL;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            // DEBOUNCE_CYCLES consecutive differing samples: accept
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/step_clock_gen.sv
// -----------------------------------------------------------------------------
// step_clock_gen
// Clean registered CPU clock from a bouncy step button or a divided free-run
// clock, selected by a slide switch.
// Ports:
//   clk        in  board clock (only clock)
//   reset      in  synchronous active-low reset
//   key_step_n in  raw step button, 0 = pressed
//   run_sw     in  raw mode switch, 1 = free-run
//   cpu_clk    out registered CPU clock
//   step_pulse out one-cycle strobe with each cpu_clk rising edge
//   step_count out number of cpu_clk rising edges since reset (wraps)
//   mode_run   out applied mode, 1 = free-run
// -----------------------------------------------------------------------------
module step_clock_gen
   import step_clk_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int RUN_HALF_PERIOD = 25_000_000,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_step_n,
   input  logic             run_sw,
   output logic             cpu_clk,
   output logic             step_pulse,
   output logic [CNT_W-1:0] step_count,
   output logic             mode_run
);

   localparam int            DW       = (RUN_HALF_PERIOD > 1) ? $clog2(RUN_HALF_PERIOD) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(RUN_HALF_PERIOD - 1);

   logic w_key_db_n;
   logic w_run_db;
   logic w_div_tc;

   step_state_t      r_state;
   logic [DW-1:0]    r_div;
   logic             r_armed;
   logic             r_cpu_clk;
   logic             r_step_pulse;
   logic [CNT_W-1:0] r_step_count;
   logic             r_mode_run;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (KEY_IDLE)
   ) u_key_db (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (key_step_n),
      .o_stable (w_key_db_n)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (SW_IDLE)
   ) u_run_db (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (run_sw),
      .o_stable (w_run_db)
   );

   assign w_div_tc = (r_div == DIV_LAST);

   // All outputs are registered alongside the state so cpu_clk is glitch-free.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= MAN_LO;
         r_div        <= '0;
         r_armed      <= 1'b1;
         r_cpu_clk    <= 1'b0;
         r_step_pulse <= 1'b0;
         r_step_count <= '0;
         r_mode_run   <= 1'b0;
      end else begin
         r_step_pulse <= 1'b0;
         case (r_state)
            MAN_LO: begin
               if (w_run_db) begin
                  r_state    <= RUN_LO;
                  r_div      <= '0;
                  r_mode_run <= 1'b1;
               end else if (!w_key_db_n && r_armed) begin
                  r_state      <= MAN_HI;
                  r_cpu_clk    <= 1'b1;
                  r_step_pulse <= 1'b1;
                  r_step_count <= r_step_count + CNT_W'(1);
               end else if (w_key_db_n) begin
                  // a release must be seen before the next press counts
                  r_armed <= 1'b1;
               end
            end
            MAN_HI: begin
               if (w_key_db_n) begin
                  r_state   <= MAN_LO;
                  r_cpu_clk <= 1'b0;
               end
            end
            RUN_LO: begin
               if (w_div_tc) begin
                  r_div <= '0;
                  if (!w_run_db) begin
                     // leave run only at the end of a low phase; a key held
                     // through the switch must be released before stepping
                     r_state    <= MAN_LO;
                     r_mode_run <= 1'b0;
                     r_armed    <= w_key_db_n;
                  end else begin
                     r_state      <= RUN_HI;
                     r_cpu_clk    <= 1'b1;
                     r_step_pulse <= 1'b1;
                     r_step_count <= r_step_count + CNT_W'(1);
                  end
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            RUN_HI: begin
               // high phase always runs to completion; mode change waits
               if (w_div_tc) begin
                  r_state   <= RUN_LO;
                  r_cpu_clk <= 1'b0;
                  r_div     <= '0;
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            default: begin
               r_state    <= MAN_LO;
               r_cpu_clk  <= 1'b0;
               r_mode_run <= 1'b0;
               r_div      <= '0;
            end
         endcase
      end
   end

   assign cpu_clk    = r_cpu_clk;
   assign step_pulse = r_step_pulse;
   assign step_count = r_step_count;
   assign mode_run   = r_mode_run;

endmodule

// File: tb/tb_step_clock_gen.sv
module tb_step_clock_gen;

   localparam int D   = 4;
   localparam int RHP = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        key_step_n = 1'b1;
   logic        run_sw = 1'b0;
   logic        cpu_clk, step_pulse, mode_run;
   logic [31:0] step_count;
   logic        cpu_clk3, step_pulse3, mode_run3;
   logic [2:0]  step_count3;

   always #5 clk = ~clk;

   step_clock_gen #(.DEBOUNCE_CYCLES(D), .RUN_HALF_PERIOD(RHP), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .key_step_n(key_step_n), .run_sw(run_sw),
      .cpu_clk(cpu_clk), .step_pulse(step_pulse), .step_count(step_count),
      .mode_run(mode_run));

   // narrow counter copy to exercise wrap-around
   step_clock_gen #(.DEBOUNCE_CYCLES(D), .RUN_HALF_PERIOD(RHP), .CNT_W(3)) dut3 (
      .clk(clk), .reset(reset), .key_step_n(key_step_n), .run_sw(run_sw),
      .cpu_clk(cpu_clk3), .step_pulse(step_pulse3), .step_count(step_count3),
      .mode_run(mode_run3));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // raw sample histories: synchronized value seen at an edge is the raw
   // value sampled two edges earlier
   logic        kq[$];
   logic        rq[$];
   logic        ksh[$];   // last D synchronized key samples
   logic        rsh[$];
   logic        m_kdb, m_rdb;
   bit          m_run, m_hi, m_rise, m_armed;
   int          m_t;      // edges spent in run mode since entry
   logic [31:0] m_count;

   function automatic logic accept(input logic q[$], input logic stable);
      if (q.size() < D) return 1'b0;
      foreach (q[i]) if (q[i] == stable) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      kq = '{1'b1, 1'b1};
      rq = '{1'b0, 1'b0};
      ksh.delete(); rsh.delete();
      m_kdb = 1'b1; m_rdb = 1'b0;
      m_run = 0; m_hi = 0; m_rise = 0; m_armed = 1; m_t = 0;
      m_count = '0;
   endtask

   task automatic model_edge(input logic k, input logic r, input logic rst);
      logic ks, rs, nk, nr;
      if (!rst) begin
         model_reset();
         return;
      end
      m_rise = 0;
      kq.push_back(k); rq.push_back(r);
      ks = kq[kq.size()-3]; rs = rq[rq.size()-3];
      if (kq.size() > 3) begin void'(kq.pop_front()); void'(rq.pop_front()); end
      ksh.push_back(ks); rsh.push_back(rs);
      if (ksh.size() > D) begin void'(ksh.pop_front()); void'(rsh.pop_front()); end
      nk = accept(ksh, m_kdb) ? ks : m_kdb;
      nr = accept(rsh, m_rdb) ? rs : m_rdb;
      // clock behaviour uses the debounced levels as they were before the edge
      if (!m_run) begin
         if (!m_hi) begin
            if (m_rdb) begin m_run = 1; m_t = 0; end
            else if (!m_kdb && m_armed) begin m_hi = 1; m_rise = 1; end
            else if (m_kdb) m_armed = 1;
         end else if (m_kdb) m_hi = 0;
      end else begin
         m_t++;
         if (m_t % RHP == 0) begin
            if ((m_t / RHP) % 2 == 1) begin      // low half just ended
               if (!m_rdb) begin m_run = 0; m_armed = m_kdb; end
               else begin m_hi = 1; m_rise = 1; end
            end else m_hi = 0;
         end
      end
      if (m_rise) m_count = m_count + 1;
      m_kdb = nk; m_rdb = nr;
   endtask

   task automatic cyc(input logic k, input logic r, input logic rst);
      key_step_n = k; run_sw = r; reset = rst;
      @(posedge clk);
      model_edge(k, r, rst);
      @(negedge clk);
      chk("cpu_clk",    cpu_clk,    m_hi);
      chk("step_pulse", step_pulse, m_rise);
      chk("step_count", step_count, m_count);
      chk("mode_run",   mode_run,   m_run);
      chk("count3",     step_count3, m_count[2:0]);
      chk("cpu_clk3",   cpu_clk3,   m_hi);
   endtask

   task automatic run_n(input int n, input logic k, input logic r);
      for (int i = 0; i < n; i++) cyc(k, r, 1'b1);
   endtask

   task automatic wait_hi(input logic k, input logic r);
      int n;
      n = 0;
      while (cpu_clk !== 1'b1 && n < 60) begin cyc(k, r, 1'b1); n++; end
      chk("wait_hi_timeout", cpu_clk, 1'b1);
   endtask

   logic [31:0] base;
   int          pulses;

   initial begin
      model_reset();
      // reset held with key pressed
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
      chk("rst_cpu_clk", cpu_clk, 0);
      chk("rst_count", step_count, 0);
      chk("rst_mode", mode_run, 0);
      // key still pressed: cpu_clk rises on the 7th edge after release
      run_n(6, 1'b0, 1'b0);
      chk("lat_before", cpu_clk, 0);
      run_n(1, 1'b0, 1'b0);
      chk("lat_rise", cpu_clk, 1);
      chk("lat_pulse", step_pulse, 1);
      chk("lat_count", step_count, 1);
      run_n(12, 1'b1, 1'b0);
      chk("release_lo", cpu_clk, 0);

      // bouncy press: exactly one edge
      base = step_count;
      cyc(1'b0, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b1);
      run_n(10, 1'b0, 1'b0);
      run_n(6, 1'b1, 1'b0);
      chk("rel_hold_hi", cpu_clk, 1);
      run_n(1, 1'b1, 1'b0);
      chk("rel_7_lo", cpu_clk, 0);
      chk("bounce_one", step_count - base, 1);

      // free-run: count pulses over 5 rising edges
      base = step_count; pulses = 0;
      for (int i = 0; i < 60 && (step_count - base) < 5; i++) begin
         cyc(1'b1, 1'b1, 1'b1);
         if (step_pulse) pulses++;
      end
      chk("run_5_edges", step_count - base, 5);
      chk("run_5_pulses", pulses, 5);

      // drop switch during high phase: high completes, then manual
      wait_hi(1'b1, 1'b1);
      run_n(30, 1'b1, 1'b0);
      chk("drop_mode", mode_run, 0);
      chk("drop_lo", cpu_clk, 0);
      base = step_count;
      run_n(10, 1'b1, 1'b0);
      chk("drop_idle", step_count - base, 0);

      // key held across run->manual: needs release and re-press
      run_n(20, 1'b0, 1'b1);
      base = step_count;
      run_n(30, 1'b0, 1'b0);
      chk("held_mode", mode_run, 0);
      chk("held_no_edge", cpu_clk, 0);
      run_n(10, 1'b1, 1'b0);
      run_n(10, 1'b0, 1'b0);
      chk("repress_edge", cpu_clk, 1);
      run_n(10, 1'b1, 1'b0);

      // narrow counter wraps 7 -> 0
      while (step_count3 != 3'd7 && n_vec < 200000) begin
         run_n(8, 1'b0, 1'b0); run_n(8, 1'b1, 1'b0);
      end
      run_n(8, 1'b0, 1'b0);
      chk("wrap3_zero", step_count3, 0);
      run_n(8, 1'b1, 1'b0);

      // reset during run high phase
      wait_hi(1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("rst_hi_clk", cpu_clk, 0);
      chk("rst_hi_mode", mode_run, 0);

      // randomized segments with occasional bounce and reset
      begin
         logic k, r, kk;
         k = 1'b1; r = 1'b0;
         for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 3) == 0) r = ~r;
            k = $urandom_range(0, 1);
            for (int i = $urandom_range(1, 14); i > 0; i--) begin
               kk = ($urandom_range(0, 9) == 0) ? ~k : k;
               cyc(kk, r, ($urandom_range(0, 199) != 0));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Upstream stage of the board top level. Turns the raw, bouncy KEY[3] push-button and a run/step slide switch into a clean, glitch-free, registered clock for the MIPS single-cycle core.
- Supports two modes:
  - Manual single-step: one cpu_clk rising edge per debounced press.
  - Free-run: cpu_clk divided down from the 50 MHz board clock.
- Also outputs a one-cycle step strobe and an executed-step counter, which the top level can show on the displays or LEDs.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles an input must hold a new level before it is accepted (20 ms at 50 MHz); must be >= 2
RUN_HALF_PERIOD, 25_000_000, clk cycles per cpu_clk half-period in run mode (1 Hz); must be >= 1
CNT_W, 32, width of step_count

Ports:
clk  in  1  board clock (CLOCK_50); the only clock
reset  in  1  synchronous, active-low reset (0 = reset); sampled on rising edge of clk
key_step_n  in  1  raw KEY[3], asynchronous, 0 = pressed
run_sw  in  1  raw slide switch, asynchronous, 1 = free-run, 0 = manual step
cpu_clk  out  1  registered clock to MIPS processor
step_pulse  out  1  one-clk-cycle strobe, coincident with each cpu_clk 0->1 transition
step_count  out  CNT_W  number of cpu_clk rising edges since reset
mode_run  out  1  currently active mode (debounced, applied), 1 = run

Behaviour:
Reset (reset==0 at a clk edge):
- Synchronizer flops reset to their idle level: key = 1, switch = 0.
- Debounced key_n = 1; debounced run = 0; debounce counters = 0.
- State = MAN_LO; cpu_clk = 0; step_pulse = 0; step_count = 0; mode_run = 0; divider = 0.
- A reset asserted mid-press or mid-run half-period aborts immediately. No cpu_clk edge is produced in the reset cycle.

Input conditioning:
- Each raw input passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: the counter clears whenever synced == stable. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, stable <= synced and the counter clears.
- A change is therefore accepted exactly DEBOUNCE_CYCLES cycles after the synced level first differs and stays different.
- Any bounce back to the stable level resets the count.

FSM (states MAN_LO, MAN_HI, RUN_LO, RUN_HI); cpu_clk = 1 exactly in the *_HI states, registered:
- MAN_LO:
  - If run_db==1 -> RUN_LO, with divider cleared.
  - Else if key_db_n==0 -> MAN_HI.
- MAN_HI: if key_db_n==1 -> MAN_LO. A run_sw change is ignored while in this state.
- RUN_LO: the divider counts 0..RUN_HALF_PERIOD-1. At terminal count:
  - If run_db==0 -> MAN_LO.
  - Else -> RUN_HI, with divider cleared.
- RUN_HI: at terminal count -> RUN_LO, with divider cleared. A run_sw change is deferred until RUN_LO terminal count, so the high phase is never truncated.

Mode switching and outputs:
- Mode changes therefore only happen with cpu_clk low, so no runt pulses occur.
- mode_run = 1 in RUN_LO/RUN_HI.
- The key is ignored in run mode. A key held while switching run->manual produces no edge until it is released and pressed again: entering MAN_LO requires first seeing key_db_n==1 (track with a "armed" flag cleared on entry when key held).
- step_pulse: registered, high in the same cycle that cpu_clk first reads 1.
- step_count: increments by 1 in that same cycle. It wraps from 2^CNT_W-1 to 0 with no flag.

Latency: a clean press propagates to cpu_clk = 1 in 2 (sync) + DEBOUNCE_CYCLES + 1 (FSM register) cycles.

Decomposition:
- Package step_clk_pkg holds:
  - typedef enum logic [1:0] {MAN_LO, MAN_HI, RUN_LO, RUN_HI} step_state_t
  - localparam KEY_IDLE = 1'b1
- Sub-module key_debounce: 2-flop synchronizer plus counter, parameters DEBOUNCE_CYCLES and RESET_VAL. It is instantiated twice (key, switch).
- The top file holds the FSM, divider and counter.

Test Plan (DEBOUNCE_CYCLES=4, RUN_HALF_PERIOD=3):
- Reset held 3 cycles with key_step_n=0 -> cpu_clk=0, step_count=0, state MAN_LO; release reset, key still 0 -> cpu_clk rises 7 cycles later, step_pulse 1 cycle, count=1.
- Key pressed with bounce 0,1,0,1 on alternate cycles then stable 0 for 10 cycles, then released -> exactly one cpu_clk pulse, step_count=1; cpu_clk returns to 0 seven cycles after clean release.
- run_sw=1 stable -> after debounce, cpu_clk toggles every 3 cycles (period 6); after 5 rising edges step_count=5, step_pulse seen 5 times.
- run_sw dropped to 0 while in RUN_HI -> high phase completes the full 3 cycles, next state MAN_LO, mode_run=0, no further edges with key idle.
- Key held low while switching run->manual -> no edge until key released and re-pressed; then one edge.
- Preload/force step_count = 2^32-1, one press -> step_count=0, step_pulse=1; reset asserted while in RUN_HI -> next cycle cpu_clk=0, mode_run=0.
